// File: rtl/id_pipe_stage_if.sv
// ID/EX output bundle of the decode stage with its valid/ready handshake.
interface id_pipe_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            out_valid_o;
  logic            out_ready_i;
  logic [6:0]      aluop_o;
  logic [2:0]      alusel_o;
  logic [6:0]      alusel2_o;
  logic [XLEN-1:0] reg1_o;
  logic [XLEN-1:0] reg2_o;
  logic [4:0]      wd_o;
  logic            wreg_o;
  logic [XLEN-1:0] pc_o;
  logic            illegal_o;

  modport master (
    output out_valid_o, aluop_o, alusel_o, alusel2_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, illegal_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, aluop_o, alusel_o, alusel2_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, illegal_o,
    output out_ready_i
  );
endinterface

// File: rtl/id_pipe_stage.sv
// RV32I decode stage (OP-IMM/OP/LUI/AUIPC) with prioritised forwarding,
// load-use stall detection and a valid/ready ID/EX output register.
module id_pipe_stage #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [31:0]             inst_i,
  output logic                    reg1_read_o,
  output logic                    reg2_read_o,
  output logic [4:0]              reg1_addr_o,
  output logic [4:0]              reg2_addr_o,
  input  logic [XLEN-1:0]         reg1_data_i,
  input  logic [XLEN-1:0]         reg2_data_i,
  input  logic [NUM_FWD-1:0]      fwd_wreg_i,
  input  logic [NUM_FWD-1:0]      fwd_load_i,
  input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
  input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
  input  logic                    flush_i,
  output logic [CNT_W-1:0]        stall_cnt_o,
  id_pipe_stage_if.master         ex_if
);

  typedef enum logic [6:0] {
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [6:0]      aluop;
    logic [2:0]      alusel;
    logic [6:0]      alusel2;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [4:0]      wd;
    logic            wreg;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign funct7 = inst_i[31:25];

  logic [XLEN-1:0] src1, src2;
  logic            ld1, ld2, hit1, hit2;

  // First matching channel wins; x0 is never forwarded and never stalls.
  always_comb begin
    src1 = reg1_data_i;
    src2 = reg2_data_i;
    ld1  = 1'b0;
    ld2  = 1'b0;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (!hit1 && fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == rs1)) begin
        hit1 = 1'b1;
        src1 = fwd_wdata_i[XLEN*k +: XLEN];
        ld1  = fwd_load_i[k];
      end
      if (!hit2 && fwd_wreg_i[k] && (fwd_wd_i[5*k +: 5] == rs2)) begin
        hit2 = 1'b1;
        src2 = fwd_wdata_i[XLEN*k +: XLEN];
        ld2  = fwd_load_i[k];
      end
    end
    if (rs1 == '0) begin
      src1 = '0;
      ld1  = 1'b0;
    end
    if (rs2 == '0) begin
      src2 = '0;
      ld2  = 1'b0;
    end
  end

  bundle_t         dec;
  logic            rd1, rd2, a_is_pc;
  logic [XLEN-1:0] imm;

  always_comb begin
    dec        = '0;
    dec.aluop  = opcode;
    dec.alusel = funct3;
    dec.wd     = rd;
    dec.pc     = pc_i;
    rd1        = 1'b0;
    rd2        = 1'b0;
    a_is_pc    = 1'b0;
    imm        = '0;
    case (opcode)
      OPC_OP_IMM: begin
        rd1      = 1'b1;
        dec.wreg = 1'b1;
        if (funct3 == 3'b001 || funct3 == 3'b101) imm = XLEN'(inst_i[24:20]);
        else                                      imm = XLEN'($signed(inst_i[31:20]));
        if (funct3 == 3'b101) dec.alusel2 = funct7;
      end
      OPC_OP: begin
        rd1      = 1'b1;
        rd2      = 1'b1;
        dec.wreg = 1'b1;
        if (funct3 == 3'b000 || funct3 == 3'b101) dec.alusel2 = funct7;
      end
      OPC_LUI: begin
        dec.wreg = 1'b1;
        imm      = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      OPC_AUIPC: begin
        dec.wreg = 1'b1;
        a_is_pc  = 1'b1;
        imm      = XLEN'($signed({inst_i[31:12], 12'b0}));
      end
      default: dec.illegal = 1'b1;
    endcase
    if (rd == '0) dec.wreg = 1'b0;
    dec.reg1 = a_is_pc ? pc_i : (rd1 ? src1 : '0);
    dec.reg2 = rd2 ? src2 : imm;
  end

  assign reg1_read_o = rd1;
  assign reg2_read_o = rd2;
  assign reg1_addr_o = rs1;
  assign reg2_addr_o = rs2;

  logic             hazard, stall;
  bundle_t          bundle_q, bundle_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign hazard     = (rd1 & ld1) | (rd2 & ld2);
  assign stall      = in_valid_i & hazard;
  assign in_ready_o = ~flush_i & ~stall & (~valid_q | ex_if.out_ready_i);

  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_d  = 1'b1;
      bundle_d = dec;
    end else if (ex_if.out_ready_i) begin
      valid_d = 1'b0;
    end
    if (stall && !flush_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stall_cnt_o       = cnt_q;
  assign ex_if.out_valid_o = valid_q;
  assign ex_if.aluop_o     = bundle_q.aluop;
  assign ex_if.alusel_o    = bundle_q.alusel;
  assign ex_if.alusel2_o   = bundle_q.alusel2;
  assign ex_if.reg1_o      = bundle_q.reg1;
  assign ex_if.reg2_o      = bundle_q.reg2;
  assign ex_if.wd_o        = bundle_q.wd;
  assign ex_if.wreg_o      = bundle_q.wreg;
  assign ex_if.pc_o        = bundle_q.pc;
  assign ex_if.illegal_o   = bundle_q.illegal;

endmodule
